stage3_hazard_controller: RTL and testbench

Central stall/flush sequencer for the 3-stage (fetch / execute / mem) pipeline. It watches data-memory and instruction-memory wait states, load-use dependencies, execute-stage branch mispredicts and halt retirement. It drives PC enable, redirect strobe and the hold/bubble controls of the IF/EX and EX/MEM latches. It sits beside the forwarding unit; load data is never forwarded, so load-use hazards are resolved here by a bubble.

---
 rtl/stage3_hazard_controller_if.sv | 44 ++++
 rtl/stage3_hazard_controller.sv | 133 +++++++++++++
 tb/tb_stage3_hazard_controller.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/stage3_hazard_controller_if.sv
// Hazard-controller bus: hazard information coming from the pipeline and the
// PC / latch controls going back to it. The pipeline side is the master, the
// hazard controller is the slave.
interface stage3_hazard_controller_if #(
    parameter int CNT_W = 32
);
    // Hazard information from execute / mem stages and the memories
    logic [4:0]       rs1_e;
    logic [4:0]       rs2_e;
    logic             rs1_used_e;
    logic             rs2_used_e;
    logic [4:0]       rd_mem;
    logic             regWEN_mem;
    logic             load_mem;
    logic             store_mem;
    logic             dmem_busy;
    logic             imem_busy;
    logic             mispredict_e;
    logic             halt_mem;

    // Controls back to the pipeline
    logic             pc_en;
    logic             pc_redirect;
    logic             stall_if_ex;
    logic             flush_if_ex;
    logic             stall_ex_mem;
    logic             flush_ex_mem;
    logic             halted;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output rs1_e, rs2_e, rs1_used_e, rs2_used_e, rd_mem, regWEN_mem,
               load_mem, store_mem, dmem_busy, imem_busy, mispredict_e, halt_mem,
        input  pc_en, pc_redirect, stall_if_ex, flush_if_ex, stall_ex_mem,
               flush_ex_mem, halted, stall_count
    );

    modport slave (
        input  rs1_e, rs2_e, rs1_used_e, rs2_used_e, rd_mem, regWEN_mem,
               load_mem, store_mem, dmem_busy, imem_busy, mispredict_e, halt_mem,
        output pc_en, pc_redirect, stall_if_ex, flush_if_ex, stall_ex_mem,
               flush_ex_mem, halted, stall_count
    );
endinterface

// File: rtl/stage3_hazard_controller.sv
// Stall/flush sequencer for the fetch / execute / mem pipeline.
// Resolves data-memory waits, load-use dependencies (no load forwarding),
// execute-stage mispredicts against in-flight fetches, and halt retirement.
// Controls are combinational from state and the current hazard inputs.
module stage3_hazard_controller #(
    parameter int CNT_W = 32
) (
    input  logic                         CLK,
    input  logic                         nRST,
    stage3_hazard_controller_if.slave    bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        HALTED   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] stall_count_reg;

    logic mem_stall;
    logic load_use;
    logic rs1_hit;
    logic rs2_hit;

    // Ungated control values; forced to zero below while reset is asserted
    logic pc_en_c;
    logic pc_redirect_c;
    logic stall_if_ex_c;
    logic flush_if_ex_c;
    logic stall_ex_mem_c;
    logic flush_ex_mem_c;
    logic halted_c;

    assign mem_stall = (bus.load_mem | bus.store_mem) & bus.dmem_busy;
    assign rs1_hit   = bus.rs1_used_e & (bus.rs1_e == bus.rd_mem);
    assign rs2_hit   = bus.rs2_used_e & (bus.rs2_e == bus.rd_mem);
    assign load_use  = bus.load_mem & bus.regWEN_mem & (bus.rd_mem != 5'd0)
                     & (rs1_hit | rs2_hit);

    // State register; reset drops any pending redirect
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and controls, strict priority in RUN
    always_comb begin
        state_next     = state_reg;
        pc_en_c        = 1'b0;
        pc_redirect_c  = 1'b0;
        stall_if_ex_c  = 1'b0;
        flush_if_ex_c  = 1'b0;
        stall_ex_mem_c = 1'b0;
        flush_ex_mem_c = 1'b0;
        halted_c       = 1'b0;
        unique case (state_reg)
            RUN: begin
                if (mem_stall) begin
                    // Whole pipe frozen; execute hazards re-present next cycle
                    stall_if_ex_c  = 1'b1;
                    stall_ex_mem_c = 1'b1;
                end else if (bus.halt_mem) begin
                    flush_if_ex_c  = 1'b1;
                    flush_ex_mem_c = 1'b1;
                    state_next     = HALTED;
                end else if (load_use) begin
                    // Load writes the regfile this edge; dependent op re-reads
                    stall_if_ex_c  = 1'b1;
                    flush_ex_mem_c = 1'b1;
                end else if (bus.mispredict_e && bus.imem_busy) begin
                    // In-flight fetch is wrong-path: wait it out
                    flush_if_ex_c  = 1'b1;
                    state_next     = REDIRECT;
                end else if (bus.mispredict_e) begin
                    pc_redirect_c  = 1'b1;
                    pc_en_c        = 1'b1;
                    flush_if_ex_c  = 1'b1;
                end else if (bus.imem_busy) begin
                    flush_if_ex_c  = 1'b1;
                end else begin
                    pc_en_c        = 1'b1;
                end
            end
            REDIRECT: begin
                // Discard every fetch, including the stale one as it lands
                flush_if_ex_c  = 1'b1;
                stall_ex_mem_c = mem_stall;
                if (bus.halt_mem && !mem_stall) begin
                    flush_ex_mem_c = 1'b1;
                    state_next     = HALTED;
                end else if (!bus.imem_busy) begin
                    pc_redirect_c  = 1'b1;
                    pc_en_c        = 1'b1;
                    state_next     = RUN;
                end
            end
            HALTED: begin
                halted_c       = 1'b1;
                stall_if_ex_c  = 1'b1;
                stall_ex_mem_c = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Saturating count of PC-frozen cycles, frozen once halted
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_count_reg <= '0;
        end else if ((state_reg != HALTED) && !pc_en_c
                     && (stall_count_reg != CNT_MAX)) begin
            stall_count_reg <= stall_count_reg + 1'b1;
        end
    end

    assign bus.pc_en        = nRST & pc_en_c;
    assign bus.pc_redirect  = nRST & pc_redirect_c;
    assign bus.stall_if_ex  = nRST & stall_if_ex_c;
    assign bus.flush_if_ex  = nRST & flush_if_ex_c;
    assign bus.stall_ex_mem = nRST & stall_ex_mem_c;
    assign bus.flush_ex_mem = nRST & flush_ex_mem_c;
    assign bus.halted       = nRST & halted_c;
    assign bus.stall_count  = stall_count_reg;
endmodule

// File: tb/tb_stage3_hazard_controller.sv
// Directed bench for stage3_hazard_controller. A 32-bit-counter instance runs
// the directed sequence; a 4-bit-counter instance shadows the same inputs to
// exercise counter saturation.
module tb_stage3_hazard_controller;
    logic CLK;
    logic nRST;
    int   checks;
    int   errors;

    stage3_hazard_controller_if #(.CNT_W(32)) ifb ();
    stage3_hazard_controller_if #(.CNT_W(4))  ifs ();

    stage3_hazard_controller #(.CNT_W(32)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (ifb.slave)
    );

    stage3_hazard_controller #(.CNT_W(4)) dut_small (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (ifs.slave)
    );

    assign ifs.rs1_e        = ifb.rs1_e;
    assign ifs.rs2_e        = ifb.rs2_e;
    assign ifs.rs1_used_e   = ifb.rs1_used_e;
    assign ifs.rs2_used_e   = ifb.rs2_used_e;
    assign ifs.rd_mem       = ifb.rd_mem;
    assign ifs.regWEN_mem   = ifb.regWEN_mem;
    assign ifs.load_mem     = ifb.load_mem;
    assign ifs.store_mem    = ifb.store_mem;
    assign ifs.dmem_busy    = ifb.dmem_busy;
    assign ifs.imem_busy    = ifb.imem_busy;
    assign ifs.mispredict_e = ifb.mispredict_e;
    assign ifs.halt_mem     = ifb.halt_mem;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Control vector order: pc_en, pc_redirect, stall_if_ex, flush_if_ex,
    // stall_ex_mem, flush_ex_mem, halted
    localparam logic [6:0] C_IDLE   = 7'b1000000;
    localparam logic [6:0] C_ZERO   = 7'b0000000;
    localparam logic [6:0] C_MSTALL = 7'b0010100;
    localparam logic [6:0] C_LU     = 7'b0010010;
    localparam logic [6:0] C_REDIR  = 7'b1101000;
    localparam logic [6:0] C_FIF    = 7'b0001000;
    localparam logic [6:0] C_RDMS   = 7'b0001100;
    localparam logic [6:0] C_HALT   = 7'b0001010;
    localparam logic [6:0] C_HALTED = 7'b0010101;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ifb.rs1_e = 5'd0; ifb.rs2_e = 5'd0;
        ifb.rs1_used_e = 1'b0; ifb.rs2_used_e = 1'b0;
        ifb.rd_mem = 5'd0; ifb.regWEN_mem = 1'b0;
        ifb.load_mem = 1'b0; ifb.store_mem = 1'b0;
        ifb.dmem_busy = 1'b0; ifb.imem_busy = 1'b0;
        ifb.mispredict_e = 1'b0; ifb.halt_mem = 1'b0;
    endtask

    task automatic chk_ctl(input string tag, input logic [6:0] expv);
        logic [6:0] obs;
        #1;
        obs = {ifb.pc_en, ifb.pc_redirect, ifb.stall_if_ex, ifb.flush_if_ex,
               ifb.stall_ex_mem, ifb.flush_ex_mem, ifb.halted};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
        $display("check %s ctl=%b", tag, obs);
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] expv);
        checks++;
        assert (ifb.stall_count === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, ifb.stall_count, expv);
        end
        $display("check %s stall_count=%0d", tag, ifb.stall_count);
    endtask

    task automatic chk_small(input string tag, input logic [3:0] expv);
        checks++;
        assert (ifs.stall_count === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, ifs.stall_count, expv);
        end
        $display("check %s small_count=%0d", tag, ifs.stall_count);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        nRST = 1'b0;
        // Mispredict present during reset must not leak to the outputs
        ifb.mispredict_e = 1'b1;
        tick();
        tick();
        chk_ctl("reset_outputs", C_ZERO);
        chk_cnt("reset_count", 0);
        ifb.mispredict_e = 1'b0;
        nRST = 1'b1;
        chk_ctl("run_idle", C_IDLE);
        tick();
        chk_cnt("idle_no_count", 0);

        // Load x5 with 3 busy cycles, execute reads x5 via rs1
        ifb.load_mem = 1'b1; ifb.regWEN_mem = 1'b1; ifb.rd_mem = 5'd5;
        ifb.rs1_e = 5'd5; ifb.rs1_used_e = 1'b1; ifb.dmem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_ctl($sformatf("mem_stall_%0d", i), C_MSTALL);
            tick();
        end
        chk_cnt("mem_stall_count", 3);
        ifb.dmem_busy = 1'b0;
        chk_ctl("load_use_bubble", C_LU);
        tick();
        chk_cnt("load_use_count", 4);
        ifb.load_mem = 1'b0; ifb.regWEN_mem = 1'b0;
        chk_ctl("after_bubble_run", C_IDLE);
        tick();

        // Load to x0 never creates a bubble
        ifb.load_mem = 1'b1; ifb.regWEN_mem = 1'b1; ifb.rd_mem = 5'd0;
        ifb.rs1_e = 5'd0; ifb.rs1_used_e = 1'b1;
        chk_ctl("load_rd0_no_bubble", C_IDLE);
        // Matching rs1 that is not used: no bubble
        ifb.rd_mem = 5'd5; ifb.rs1_e = 5'd5; ifb.rs1_used_e = 1'b0;
        ifb.rs2_e = 5'd3; ifb.rs2_used_e = 1'b1;
        chk_ctl("rs1_unused_no_bubble", C_IDLE);
        // rs2 match does bubble
        ifb.rs2_e = 5'd5;
        chk_ctl("rs2_load_use", C_LU);
        tick();
        chk_cnt("rs2_bubble_count", 5);
        idle();

        // Mispredict, fetch idle: single-cycle redirect, stay in RUN
        ifb.mispredict_e = 1'b1;
        chk_ctl("mispredict_direct", C_REDIR);
        tick();
        ifb.mispredict_e = 1'b0;
        chk_ctl("mispredict_stay_run", C_IDLE);
        chk_cnt("mispredict_no_count", 5);

        // Mispredict with fetch busy: wait in REDIRECT
        ifb.mispredict_e = 1'b1; ifb.imem_busy = 1'b1;
        chk_ctl("mispredict_busy_run", C_FIF);
        tick();
        ifb.mispredict_e = 1'b0;
        ifb.store_mem = 1'b1; ifb.dmem_busy = 1'b1;
        chk_ctl("redirect_busy_memstall", C_RDMS);
        tick();
        ifb.store_mem = 1'b0; ifb.dmem_busy = 1'b0; ifb.imem_busy = 1'b0;
        chk_ctl("redirect_complete", C_REDIR);
        chk_cnt("redirect_count", 7);
        tick();
        chk_ctl("redirect_back_run", C_IDLE);
        chk_cnt("redirect_done_count", 7);

        // Mispredict together with load_use: bubble first
        ifb.load_mem = 1'b1; ifb.regWEN_mem = 1'b1; ifb.rd_mem = 5'd7;
        ifb.rs1_e = 5'd7; ifb.rs1_used_e = 1'b1; ifb.mispredict_e = 1'b1;
        chk_ctl("lu_beats_mispredict", C_LU);
        tick();
        ifb.load_mem = 1'b0; ifb.regWEN_mem = 1'b0;
        chk_ctl("mispredict_after_lu", C_REDIR);
        tick();
        chk_cnt("lu_mp_count", 8);
        // Mispredict together with mem_stall: full stall, no flushes
        ifb.store_mem = 1'b1; ifb.dmem_busy = 1'b1;
        chk_ctl("memstall_beats_mispredict", C_MSTALL);
        tick();
        ifb.store_mem = 1'b0; ifb.dmem_busy = 1'b0;
        chk_ctl("mispredict_after_memstall", C_REDIR);
        tick();
        chk_cnt("ms_mp_count", 9);
        idle();

        // Long data stall drives the 4-bit counter into saturation
        ifb.store_mem = 1'b1; ifb.dmem_busy = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk_cnt("long_stall_count", 29);
        chk_small("small_saturated", 4'd15);
        idle();

        // Halt: one flush cycle then sticky HALTED
        ifb.halt_mem = 1'b1;
        chk_ctl("halt_flush", C_HALT);
        tick();
        ifb.halt_mem = 1'b0;
        chk_ctl("halted_state", C_HALTED);
        chk_cnt("halt_count", 30);
        ifb.mispredict_e = 1'b1; ifb.imem_busy = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk_ctl("halted_sticky", C_HALTED);
        chk_cnt("halted_count_frozen", 30);
        chk_small("small_frozen", 4'd15);

        // Asynchronous reset mid-HALTED
        idle();
        nRST = 1'b0;
        chk_ctl("reset_in_halted", C_ZERO);
        chk_cnt("reset_in_halted_count", 0);
        chk_small("reset_small_count", 4'd0);
        nRST = 1'b1;
        chk_ctl("run_after_halt_reset", C_IDLE);
        tick();

        // Reset mid-REDIRECT drops the pending redirect
        ifb.mispredict_e = 1'b1; ifb.imem_busy = 1'b1;
        tick();
        ifb.mispredict_e = 1'b0;
        chk_ctl("redirect_before_reset", C_FIF);
        nRST = 1'b0;
        chk_ctl("reset_in_redirect", C_ZERO);
        ifb.imem_busy = 1'b0;
        nRST = 1'b1;
        chk_ctl("redirect_dropped", C_IDLE);
        tick();
        chk_cnt("after_redirect_reset_count", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
